// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the fft frame scheduler.
package fft_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic CH_FFT  = 1'b0;
  localparam logic CH_IFFT = 1'b1;

  // Two's complement negate of the low w bits of x; the most-negative value maps to the most-positive.
  function automatic logic [31:0] sat_neg(input logic [31:0] x, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] minv;
    logic [31:0] xm;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv = 32'd1 << (w - 32'd1);
    xm   = x & mask;
    if (xm == minv) return minv - 32'd1;
    return (32'd0 - xm) & mask;
  endfunction

endpackage

// File: rtl/fft_sched_tagfifo.sv
// Owner-tag FIFO for frames in flight through the core; 1-bit entries, same-cycle push/pop allowed.
module fft_sched_tagfifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic iclk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout_c,
  output logic full_c,
  output logic empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             wr;
  logic             rd;

  assign full_c  = (cnt == DEPTH_V);
  assign empty_c = (cnt == '0);
  assign dout_c  = mem[rptr];
  assign wr      = push & (~full_c | pop);
  assign rd      = pop & ~empty_c;

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Round-robin frame scheduler sharing one streaming fft core between an FFT and an IFFT channel.
// Optional statistics counters are enabled with FFT_SCHED_STAT_EN.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int unsigned REAL_WIDTH   = 18,
  parameter int unsigned IMGN_WIDTH   = 18,
  parameter int unsigned TOTAL_STAGE  = 11,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   iclk,
  input  logic                   rst_n,
  input  logic                   s0_valid,
  output logic                   s0_ready,
  input  logic [REAL_WIDTH-1:0]  s0_real,
  input  logic [IMGN_WIDTH-1:0]  s0_imag,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [REAL_WIDTH-1:0]  s1_real,
  input  logic [IMGN_WIDTH-1:0]  s1_imag,
  output logic                   fft_en,
  output logic [TOTAL_STAGE-1:0] fft_addr,
  output logic [REAL_WIDTH-1:0]  fft_real,
  output logic [IMGN_WIDTH-1:0]  fft_imag,
  input  logic                   fft_oen,
  input  logic [TOTAL_STAGE-1:0] fft_oaddr,
  input  logic [REAL_WIDTH-1:0]  fft_oreal,
  input  logic [IMGN_WIDTH-1:0]  fft_oimag,
  output logic                   m_valid,
  output logic                   m_chan,
  output logic [TOTAL_STAGE-1:0] m_addr,
  output logic [REAL_WIDTH-1:0]  m_real,
  output logic [IMGN_WIDTH-1:0]  m_imag,
  output logic                   m_sof,
  output logic                   m_eof,
`ifdef FFT_SCHED_STAT_EN
  output logic [31:0]            stat_frm0,
  output logic [31:0]            stat_frm1,
  output logic [31:0]            stat_stall,
`endif
  output logic                   err_orphan
);

  localparam logic [TOTAL_STAGE-1:0] LAST_IDX = '1;

  state_t                 state, state_n;
  logic                   gch, gch_n;
  logic                   rr, rr_n;
  logic                   rdy0_n, rdy1_n;
  logic [TOTAL_STAGE-1:0] in_cnt, in_cnt_n;
  logic [TOTAL_STAGE-1:0] out_cnt;
  logic                   push, pop, full, empty, head;
  logic                   hs, oen_ok;

  assign hs     = (s0_valid & s0_ready) | (s1_valid & s1_ready);
  assign oen_ok = fft_oen & ~empty;
  assign pop    = oen_ok & (out_cnt == LAST_IDX);

  // Frame grant and input sequencing.
  always_comb begin
    state_n  = state;
    gch_n    = gch;
    rr_n     = rr;
    rdy0_n   = s0_ready;
    rdy1_n   = s1_ready;
    in_cnt_n = in_cnt;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (!full && (s0_valid || s1_valid)) begin
          push    = 1'b1;
          gch_n   = (s0_valid && s1_valid) ? rr : s1_valid;
          rdy0_n  = (gch_n == CH_FFT);
          rdy1_n  = (gch_n == CH_IFFT);
          state_n = FRAME;
        end
      end
      FRAME: begin
        if (hs) begin
          in_cnt_n = in_cnt + TOTAL_STAGE'(1);
          if (in_cnt == LAST_IDX) begin
            state_n = IDLE;
            rdy0_n  = 1'b0;
            rdy1_n  = 1'b0;
            rr_n    = ~gch;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gch      <= CH_FFT;
      rr       <= CH_FFT;
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      in_cnt   <= '0;
    end else begin
      state    <= state_n;
      gch      <= gch_n;
      rr       <= rr_n;
      s0_ready <= rdy0_n;
      s1_ready <= rdy1_n;
      in_cnt   <= in_cnt_n;
    end
  end

  // Core input register; IFFT samples are conjugated on the way in.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      fft_en   <= 1'b0;
      fft_addr <= '0;
      fft_real <= '0;
      fft_imag <= '0;
    end else begin
      fft_en <= hs;
      if (hs) begin
        fft_addr <= in_cnt;
        if (gch == CH_IFFT) begin
          fft_real <= s1_real;
          fft_imag <= IMGN_WIDTH'(sat_neg(32'(s1_imag), IMGN_WIDTH));
        end else begin
          fft_real <= s0_real;
          fft_imag <= s0_imag;
        end
      end
    end
  end

  // Result register; owner comes from the oldest tag, IFFT results are conjugated on the way out.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_chan     <= 1'b0;
      m_addr     <= '0;
      m_real     <= '0;
      m_imag     <= '0;
      m_sof      <= 1'b0;
      m_eof      <= 1'b0;
      out_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      m_valid <= oen_ok;
      m_sof   <= oen_ok && (out_cnt == '0);
      m_eof   <= pop;
      if (oen_ok) begin
        out_cnt <= out_cnt + TOTAL_STAGE'(1);
        m_chan  <= head;
        m_addr  <= fft_oaddr;
        m_real  <= fft_oreal;
        m_imag  <= (head == CH_IFFT) ? IMGN_WIDTH'(sat_neg(32'(fft_oimag), IMGN_WIDTH)) : fft_oimag;
      end
      if (fft_oen && empty) err_orphan <= 1'b1;
    end
  end

  fft_sched_tagfifo #(
    .DEPTH(MAX_INFLIGHT)
  ) u_tagfifo (
    .iclk    (iclk),
    .rst_n   (rst_n),
    .push    (push),
    .din     (gch_n),
    .pop     (pop),
    .dout_c  (head),
    .full_c  (full),
    .empty_c (empty)
  );

`ifdef FFT_SCHED_STAT_EN
  // Completed-frame and full-FIFO stall counters.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frm0  <= '0;
      stat_frm1  <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && (head == CH_FFT))  stat_frm0 <= stat_frm0 + 32'd1;
      if (pop && (head == CH_IFFT)) stat_frm1 <= stat_frm1 + 32'd1;
      if ((state == IDLE) && full && (s0_valid || s1_valid)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized scoreboard bench for fft_frame_sched with an emulated fft core on the output side.
module tb_fft_frame_sched;

  localparam int unsigned W  = 18;
  localparam int unsigned TS = 3;
  localparam int unsigned FL = 8;

  typedef struct packed {logic [W-1:0] re; logic [W-1:0] im;} samp_t;
  typedef struct packed {logic [TS-1:0] addr; logic [W-1:0] re; logic [W-1:0] im;} fexp_t;
  typedef struct packed {logic ch; logic [TS-1:0] addr; logic [W-1:0] re; logic [W-1:0] im; logic sof; logic eof;} mexp_t;

  logic iclk = 1'b0;
  logic rst_n;
  logic s0_valid, s0_ready, s1_valid, s1_ready;
  logic [W-1:0] s0_real, s0_imag, s1_real, s1_imag;
  logic fft_en;
  logic [TS-1:0] fft_addr;
  logic [W-1:0] fft_real, fft_imag;
  logic fft_oen;
  logic [TS-1:0] fft_oaddr;
  logic [W-1:0] fft_oreal, fft_oimag;
  logic m_valid, m_chan, m_sof, m_eof, err_orphan;
  logic [TS-1:0] m_addr;
  logic [W-1:0] m_real, m_imag;

  samp_t q0[$];
  samp_t q1[$];
  fexp_t exp_fft[$];
  mexp_t exp_m[$];
  bit    ord[$];
  bit    core_pending[$];

  int tests = 0;
  int fails = 0;
  int gap_pct = 0;
  int in_cnt_tb = 0;
  int frames_in = 0;
  int cyc = 0;
  int en_first = 0;
  int en_last = 0;
  bit core_hold = 1'b0;
  bit emu_busy = 1'b0;
  bit orphan_req = 1'b0;

  fft_frame_sched #(
    .REAL_WIDTH(W), .IMGN_WIDTH(W), .TOTAL_STAGE(TS), .MAX_INFLIGHT(2)
  ) dut (
    .iclk(iclk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_real(s0_real), .s0_imag(s0_imag),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_real(s1_real), .s1_imag(s1_imag),
    .fft_en(fft_en), .fft_addr(fft_addr), .fft_real(fft_real), .fft_imag(fft_imag),
    .fft_oen(fft_oen), .fft_oaddr(fft_oaddr), .fft_oreal(fft_oreal), .fft_oimag(fft_oimag),
    .m_valid(m_valid), .m_chan(m_chan), .m_addr(m_addr), .m_real(m_real), .m_imag(m_imag),
    .m_sof(m_sof), .m_eof(m_eof), .err_orphan(err_orphan)
  );

  initial forever #5 iclk = ~iclk;
  initial forever begin @(posedge iclk); cyc++; end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, expv);
    end
  endtask

  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
    int v;
    v = -int'($signed(x));
    if (v > (2 ** (W - 1)) - 1) v = (2 ** (W - 1)) - 1;
    return W'(v);
  endfunction

  function automatic logic [W-1:0] rand_im();
    case ($urandom_range(0, 5))
      0: return W'(-5);
      1: return W'(-131072);
      2: return W'(131071);
      3: return W'(7);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [TS-1:0] bitrev(input logic [TS-1:0] v);
    logic [TS-1:0] r;
    for (int k = 0; k < TS; k++) r[k] = v[TS-1-k];
    return r;
  endfunction

  // Reference: whole frames, round-robin among channels with data, starting from channel 0.
  task automatic load_round(input int n0, input int n1, input bit special);
    int a = n0;
    int b = n1;
    bit last = 1'b1;
    bit c;
    bit sp = special;
    samp_t s;
    fexp_t f;
    while (a > 0 || b > 0) begin
      if (a > 0 && b > 0) c = ~last;
      else c = (b > 0);
      last = c;
      if (c) b--; else a--;
      ord.push_back(c);
      for (int i = 0; i < FL; i++) begin
        s.re = W'($urandom);
        s.im = rand_im();
        if (sp && c && i == 0) s.im = W'(-5);
        if (sp && c && i == 1) s.im = W'(-131072);
        if (c) q1.push_back(s); else q0.push_back(s);
        f.addr = TS'(i);
        f.re = s.re;
        f.im = c ? neg_sat(s.im) : s.im;
        exp_fft.push_back(f);
      end
      if (c) sp = 1'b0;
    end
  endtask

  task automatic flush();
    q0.delete(); q1.delete(); exp_fft.delete(); exp_m.delete();
    ord.delete(); core_pending.delete();
    in_cnt_tb = 0;
    frames_in = 0;
  endtask

  task automatic do_reset();
    @(negedge iclk);
    rst_n = 1'b0;
    repeat (2) @(negedge iclk);
    flush();
    rst_n = 1'b1;
    @(negedge iclk);
  endtask

  task automatic wait_drain(input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge iclk);
      done = (q0.size() == 0) && (q1.size() == 0) && (exp_fft.size() == 0) &&
             (exp_m.size() == 0) && (core_pending.size() == 0) && !emu_busy;
    end
    chk(nm, 64'(done), 64'(1));
  endtask

  // Source driver: decides at the falling edge which samples the next rising edge accepts.
  initial begin
    bit acc0 = 1'b0;
    bit acc1 = 1'b0;
    bit gate;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_real = '0; s0_imag = '0; s1_real = '0; s1_imag = '0;
    forever begin
      @(negedge iclk);
      if (!rst_n) begin
        acc0 = 1'b0; acc1 = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
      end else begin
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        gate = ($urandom_range(0, 99) >= gap_pct);
        s0_valid = gate && (q0.size() > 0);
        s1_valid = gate && (q1.size() > 0);
        if (s0_valid) begin s0_real = q0[0].re; s0_imag = q0[0].im; end
        if (s1_valid) begin s1_real = q1[0].re; s1_imag = q1[0].im; end
        acc0 = s0_valid && s0_ready;
        acc1 = s1_valid && s1_ready;
      end
    end
  end

  // Core input monitor.
  initial forever begin
    fexp_t e;
    fexp_t got;
    @(negedge iclk);
    if (rst_n && fft_en) begin
      chk("ready_exclusive", 64'(s0_ready & s1_ready), 64'(0));
      got = {fft_addr, fft_real, fft_imag};
      if (exp_fft.size() == 0) begin
        chk("fft_unexpected", 64'(got), 64'(0));
      end else begin
        e = exp_fft.pop_front();
        chk("fft_sample", 64'(got), 64'(e));
      end
      if (in_cnt_tb == 0) en_first = cyc;
      in_cnt_tb++;
      if (in_cnt_tb == FL) begin
        in_cnt_tb = 0;
        en_last = cyc;
        frames_in++;
        if (ord.size() > 0) core_pending.push_back(ord.pop_front());
      end
    end
  end

  // Result monitor.
  initial forever begin
    mexp_t e;
    mexp_t got;
    @(negedge iclk);
    if (rst_n && m_valid) begin
      got = {m_chan, m_addr, m_real, m_imag, m_sof, m_eof};
      if (exp_m.size() == 0) begin
        chk("m_unexpected", 64'(got), 64'(0));
      end else begin
        e = exp_m.pop_front();
        chk("m_result", 64'(got), 64'(e));
      end
    end
  end

  // Emulated fft core: replays each completed input frame as a bit-reversed output burst.
  initial begin
    bit c;
    mexp_t m;
    fft_oen = 1'b0; fft_oaddr = '0; fft_oreal = '0; fft_oimag = '0;
    forever begin
      @(negedge iclk);
      if (orphan_req) begin
        fft_oen = 1'b1;
        @(negedge iclk);
        fft_oen = 1'b0;
        orphan_req = 1'b0;
      end else if (rst_n && !core_hold && core_pending.size() > 0) begin
        c = core_pending.pop_front();
        emu_busy = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge iclk);
        for (int i = 0; i < FL; i++) begin
          while ($urandom_range(0, 99) < 20) begin fft_oen = 1'b0; @(negedge iclk); end
          fft_oen = 1'b1;
          fft_oaddr = bitrev(TS'(i));
          fft_oreal = W'($urandom);
          fft_oimag = rand_im();
          m.ch = c; m.addr = fft_oaddr; m.re = fft_oreal;
          m.im = c ? neg_sat(fft_oimag) : fft_oimag;
          m.sof = (i == 0); m.eof = (i == FL - 1);
          exp_m.push_back(m);
          @(negedge iclk);
        end
        fft_oen = 1'b0;
        emu_busy = 1'b0;
      end
    end
  end

  initial begin
    int cnt;
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge iclk);
    chk("reset_ctrl", 64'({s0_ready, s1_ready, fft_en, fft_addr, m_valid, m_chan, m_addr, m_sof, m_eof, err_orphan}), 64'(0));
    chk("reset_fft_data", 64'({fft_real, fft_imag}), 64'(0));
    chk("reset_m_data", 64'({m_real, m_imag}), 64'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge iclk);
    chk("idle_ctrl", 64'({s0_ready, s1_ready, fft_en, m_valid, err_orphan}), 64'(0));

    // Single ch0 frame, no gaps: eight consecutive core writes.
    gap_pct = 0;
    load_round(1, 0, 1'b0);
    wait_drain("drain_single");
    chk("contiguous_frame", 64'(en_last - en_first), 64'(FL - 1));

    // Randomized rounds of mixed traffic.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gap_pct = (r == 0) ? 0 : int'($urandom_range(0, 30));
      load_round(int'($urandom_range(2, 4)), int'($urandom_range(1, 4)), r == 0);
      wait_drain("drain_random");
    end

    // Full tag FIFO blocks grants until the first eof pops a tag.
    do_reset();
    core_hold = 1'b1;
    gap_pct = 0;
    load_round(3, 0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge iclk); ok = (frames_in == 2); end
    chk("fill_two_frames", 64'(ok), 64'(1));
    cnt = 0;
    repeat (10) begin @(negedge iclk); if (s0_ready || s1_ready) cnt++; end
    chk("full_blocks_ready", 64'(cnt), 64'(0));
    chk("full_no_third_frame", 64'(in_cnt_tb), 64'(0));
    core_hold = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge iclk); ok = m_eof; end
    chk("first_eof_seen", 64'(ok), 64'(1));
    chk("ready_at_eof", 64'(s0_ready), 64'(0));
    @(negedge iclk);
    chk("grant_after_pop", 64'(s0_ready), 64'(1));
    wait_drain("drain_stall");

    // Orphan core output with an empty tag FIFO.
    do_reset();
    orphan_req = 1'b1;
    cnt = 0;
    repeat (5) begin @(negedge iclk); if (m_valid) cnt++; end
    chk("orphan_no_valid", 64'(cnt), 64'(0));
    chk("orphan_flag", 64'(err_orphan), 64'(1));
    repeat (3) @(negedge iclk);
    chk("orphan_sticky", 64'(err_orphan), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("orphan_cleared", 64'(err_orphan), 64'(0));
    repeat (2) @(negedge iclk);
    flush();
    rst_n = 1'b1;
    @(negedge iclk);

    // Reset in the middle of a frame, then restart with ch0 priority.
    gap_pct = 0;
    load_round(1, 0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge iclk); ok = (in_cnt_tb >= 4); end
    chk("midframe_reached", 64'(ok), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_ctrl", 64'({s0_ready, s1_ready, fft_en, fft_addr, m_valid, err_orphan}), 64'(0));
    chk("midframe_reset_data", 64'({fft_real, fft_imag}), 64'(0));
    repeat (2) @(negedge iclk);
    flush();
    rst_n = 1'b1;
    load_round(1, 1, 1'b1);
    wait_drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
